// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and helpers for the data-memory access unit
//
// Purpose : request size encodings, FSM state encoding, word geometry and
//           small address helpers used by mem_access_unit and mem_lane_align.
// Ports   : none (package).

package mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int DATA_BITS  = 32;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // The reserved encoding 3 behaves as a word access, so bit 1 alone decides.
  function automatic logic is_word_size(input logic [1:0] size);
    return size[1];
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  // Byte offset after forcing the access to its natural alignment.
  function automatic logic [1:0] natural_offset(input logic [1:0] size, input logic [1:0] off);
    logic [1:0] o;
    case (size)
      SIZE_B:  o = off;
      SIZE_H:  o = {off[1], 1'b0};
      default: o = 2'b00;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte/half lane extraction and store merge for one word
//
// Purpose : combinational lane logic. Extracts the addressed byte/half from a
//           memory word with sign or zero extension, and merges right-justified
//           store data into the addressed lane(s) of a memory word.
// Ports   : size_i      access size (SIZE_B/H/W, 3 treated as word)
//           unsigned_i  1 = zero-extend loads, 0 = sign-extend
//           offset_i    byte offset within the word (already naturally aligned)
//           rdata_i     word read from memory
//           wdata_i     right-justified store data
//           load_data_o extended load result
//           merged_o    word to write back (unaddressed bytes from rdata_i)

module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]           size_i,
  input  logic                 unsigned_i,
  input  logic [1:0]           offset_i,
  input  logic [DATA_BITS-1:0] rdata_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  output logic [DATA_BITS-1:0] load_data_o,
  output logic [DATA_BITS-1:0] merged_o
);

  logic [WORD_BYTES-1:0] byte_mask;
  logic [DATA_BITS-1:0]  wdata_rep;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;

  // Store side: replicate the source lane across the word, then let the byte
  // mask pick which copies replace the read word.
  always_comb begin
    byte_mask = 4'b1111;
    wdata_rep = wdata_i;
    case (size_i)
      SIZE_B: begin
        byte_mask = 4'b0001 << offset_i;
        wdata_rep = {4{wdata_i[7:0]}};
      end
      SIZE_H: begin
        byte_mask = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_i[15:0]}};
      end
      default: begin
        byte_mask = 4'b1111;
        wdata_rep = wdata_i;
      end
    endcase
    merged_o = rdata_i;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (byte_mask[i]) begin
        merged_o[i*8 +: 8] = wdata_rep[i*8 +: 8];
      end
    end
  end

  // Load side: little-endian, byte 0 lives in bits [7:0].
  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SIZE_B:  load_data_o = unsigned_i ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SIZE_H:  load_data_o = unsigned_i ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for a word-wide magic memory
//
// Purpose : accepts byte/half/word loads and stores, word-aligns the memory
//           address, performs read-modify-write for sub-word stores and
//           returns sign/zero-extended load data. One request at a time.
// Config  : MEM_ACCESS_MISALIGN_CHECK_EN - when defined, misaligned halves and
//           words complete immediately with resp_err_o=1 and no memory access.
//           When undefined, resp_err_o is 0 and such requests are forced to
//           natural alignment and processed normally.
// Ports   : clk_i, rst_ni          clock, asynchronous active-low reset
//           req_valid_i/req_ready_o request handshake (ready only in IDLE)
//           req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i
//                                   request fields, latched on accept
//           resp_valid_o, resp_rdata_o, resp_err_o
//                                   one-cycle completion pulse and its data
//           mem_addr_o, mem_write_data_o, mem_weMem_o, mem_read_data_i
//                                   memory word port (read is combinational)

module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_write_data_o,
  output logic              mem_weMem_o,
  input  logic [DATA_W-1:0] mem_read_data_i
);

  state_e state_q, state_d;

  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [DATA_W-1:0] word_q;

  logic              accept;
  logic              mis_w;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;

  assign accept = req_valid_i && (state_q == ST_IDLE);

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  assign mis_w = is_misaligned(req_size_i, req_addr_i[1:0]);
`else
  assign mis_w = 1'b0;
`endif

  // Low bits are forced to natural alignment unconditionally; with the check
  // enabled a misaligned request never touches memory, so this is harmless.
  assign addr_in = {req_addr_i[ADDR_W-1:2], natural_offset(req_size_i, req_addr_i[1:0])};

  mem_lane_align u_lane (
    .size_i      (size_q),
    .unsigned_i  (uns_q),
    .offset_i    (addr_q[1:0]),
    .rdata_i     (word_q),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (mis_w)                           state_d = ST_RESP;
          else if (!req_we_i)                  state_d = ST_READ;
          else if (is_word_size(req_size_i))   state_d = ST_WRITE;
          else                                 state_d = ST_READ;
        end
      end
      ST_READ:  state_d = we_q ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request latch and read-word capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      size_q  <= SIZE_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we_i;
        size_q  <= req_size_i;
        uns_q   <= req_unsigned_i;
        addr_q  <= addr_in;
        wdata_q <= req_wdata_i;
        err_q   <= mis_w;
      end
      if (state_q == ST_READ) begin
        word_q <= mem_read_data_i;
      end
    end
  end

  // Outputs decode purely from state, so reset drops mem_weMem_o at once.
  always_comb begin
    req_ready_o      = 1'b0;
    resp_valid_o     = 1'b0;
    resp_rdata_o     = '0;
    resp_err_o       = 1'b0;
    mem_addr_o       = '0;
    mem_write_data_o = '0;
    mem_weMem_o      = 1'b0;
    case (state_q)
      ST_IDLE: req_ready_o = 1'b1;
      ST_READ: mem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
      ST_WRITE: begin
        mem_addr_o       = {addr_q[ADDR_W-1:2], 2'b00};
        mem_write_data_o = merged;
        mem_weMem_o      = 1'b1;
      end
      default: begin
        resp_valid_o = 1'b1;
        resp_err_o   = err_q;
        resp_rdata_o = (!we_q && !err_q) ? load_data : '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_weMem;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:15] = '{default: 32'd0};

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int we_consec = 0;
  logic we_prev = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_we_i         (req_we),
    .req_size_i       (req_size),
    .req_unsigned_i   (req_unsigned),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .resp_valid_o     (resp_valid),
    .resp_rdata_o     (resp_rdata),
    .resp_err_o       (resp_err),
    .mem_addr_o       (mem_addr),
    .mem_write_data_o (mem_write_data),
    .mem_weMem_o      (mem_weMem),
    .mem_read_data_i  (mem_read_data)
  );

  assign mem_read_data = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (mem_weMem) mem[mem_addr[5:2]] <= mem_write_data;
  end

  always @(negedge clk) begin
    if (mem_weMem) we_cnt <= we_cnt + 1;
    if (mem_weMem && we_prev) we_consec <= we_consec + 1;
    we_prev <= mem_weMem;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request at a negedge, lets it be accepted at the next posedge,
  // then scrambles the fields. Returns positioned at the T+1 negedge.
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_size = 2'd3; req_unsigned = ~uns;
    req_addr = 32'hFFFF_FFFD; req_wdata = 32'hDEAD_BEEF;
  endtask

  task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] exp);
    send(1'b0, size, uns, addr, 32'd0);
    chk({tag, "_t1_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_t1_we"}, {31'd0, mem_weMem}, 32'd0);
    chk({tag, "_t1_addr"}, mem_addr, {addr[31:2], 2'b00});
    @(negedge clk);
    chk({tag, "_t2_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_t2_rdata"}, resp_rdata, exp);
    chk({tag, "_t2_err"}, {31'd0, resp_err}, 32'd0);
  endtask

  task automatic do_word_store(input string tag, input logic [31:0] addr, input logic [31:0] data);
    send(1'b1, 2'd2, 1'b0, addr, data);
    chk({tag, "_t1_we"}, {31'd0, mem_weMem}, 32'd1);
    chk({tag, "_t1_addr"}, mem_addr, addr);
    chk({tag, "_t1_wdata"}, mem_write_data, data);
    chk({tag, "_t1_valid"}, {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_t2_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_t2_we"}, {31'd0, mem_weMem}, 32'd0);
    chk({tag, "_t2_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_t2_ready"}, {31'd0, req_ready}, 32'd0);
  endtask

  task automatic do_sub_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] merged);
    send(1'b1, size, 1'b0, addr, data);
    chk({tag, "_t1_we"}, {31'd0, mem_weMem}, 32'd0);
    chk({tag, "_t1_addr"}, mem_addr, {addr[31:2], 2'b00});
    @(negedge clk);
    chk({tag, "_t2_we"}, {31'd0, mem_weMem}, 32'd1);
    chk({tag, "_t2_addr"}, mem_addr, {addr[31:2], 2'b00});
    chk({tag, "_t2_wdata"}, mem_write_data, merged);
    chk({tag, "_t2_valid"}, {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_t3_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_t3_we"}, {31'd0, mem_weMem}, 32'd0);
    chk({tag, "_t3_err"}, {31'd0, resp_err}, 32'd0);
  endtask

  initial begin
    int we_expected;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_weMem", {31'd0, mem_weMem}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);

    do_word_store("ws0", 32'd0, 32'hF1F1_F1F1);
    do_load("lw0", 2'd2, 1'b0, 32'd0, 32'hF1F1_F1F1);
    do_load("lb0s", 2'd0, 1'b0, 32'd0, 32'hFFFF_FFF1);
    do_load("lb0u", 2'd0, 1'b1, 32'd0, 32'h0000_00F1);
    do_load("lb3u", 2'd0, 1'b1, 32'd3, 32'h0000_00F1);

    do_word_store("ws4", 32'd4, 32'hF2F2_F2F2);
    do_sub_store("sh6", 2'd1, 32'd6, 32'h0000_1234, 32'h1234_F2F2);
    do_load("lw4", 2'd2, 1'b0, 32'd4, 32'h1234_F2F2);
    do_load("lh6u", 2'd1, 1'b1, 32'd6, 32'h0000_1234);

    do_sub_store("sb9", 2'd0, 32'd9, 32'h0000_00AB, 32'h0000_AB00);
    do_load("lw8", 2'd2, 1'b0, 32'd8, 32'h0000_AB00);
    do_load("lh8s", 2'd1, 1'b0, 32'd8, 32'hFFFF_AB00);

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    send(1'b0, 2'd2, 1'b0, 32'd2, 32'd0);
    chk("mis_lw2_valid", {31'd0, resp_valid}, 32'd1);
    chk("mis_lw2_err", {31'd0, resp_err}, 32'd1);
    chk("mis_lw2_rdata", resp_rdata, 32'd0);
    send(1'b1, 2'd1, 1'b0, 32'd5, 32'h0000_BEEF);
    chk("mis_sh5_valid", {31'd0, resp_valid}, 32'd1);
    chk("mis_sh5_err", {31'd0, resp_err}, 32'd1);
    chk("mis_sh5_we", {31'd0, mem_weMem}, 32'd0);
    @(negedge clk);
    chk("mis_sh5_we_after", {31'd0, mem_weMem}, 32'd0);
    do_load("mis_lw4_unchanged", 2'd2, 1'b0, 32'd4, 32'h1234_F2F2);
    we_expected = 5;
`else
    do_load("unal_lw2", 2'd2, 1'b0, 32'd2, 32'hF1F1_F1F1);
    do_sub_store("unal_sh5", 2'd1, 32'd5, 32'h0000_BEEF, 32'h1234_BEEF);
    we_expected = 6;
`endif

    // Reset during the WRITE cycle of a sub-word store
    send(1'b1, 2'd1, 1'b0, 32'd12, 32'h0000_5555);
    @(negedge clk);
    chk("rstw_we_before", {31'd0, mem_weMem}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_we_async", {31'd0, mem_weMem}, 32'd0);
    chk("rstw_valid_async", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstw_ready", {31'd0, req_ready}, 32'd1);
    do_load("rstw_lw12", 2'd2, 1'b0, 32'd12, 32'h0000_0000);
    do_load("rstw_lw0", 2'd2, 1'b0, 32'd0, 32'hF1F1_F1F1);

    @(negedge clk);
    chk("we_pulse_count", we_cnt, we_expected);
    chk("we_consecutive", we_consec, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
